hazard_scoreboard: RTL

Parametrised successor to the fixed 3-stage forwarding/stall logic of the five-stage core. The block tracks every in-flight register write from EX through writeback in an internal shift-register scoreboard. From that state it generates stall, flush and operand-forward selects for any pipeline depth and any per-instruction result latency. It sits beside the ID/EX pipeline register, owns the EX-stage source-register copies, and freezes cleanly on an external memory wait.

---
 rtl/hazard_scoreboard_if.sv | 36 +++
 rtl/hazard_scoreboard.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/hazard_scoreboard_if.sv
// Pipeline-side bundle for hazard_scoreboard: ID operands and control in, stall/flush/forward selects out.
// The scoreboard side (slave) is purely combinational on these outputs; the pipeline side (master) drives ID/control.
interface hazard_scoreboard_if #(
    parameter int DEPTH = 3,
    parameter int RA_W  = 5,
    parameter int LAT_W = $clog2(DEPTH)
);
    logic             id_valid;
    logic [RA_W-1:0]  id_rs1;
    logic [RA_W-1:0]  id_rs2;
    logic             id_rs1_used;
    logic             id_rs2_used;
    logic [RA_W-1:0]  id_rd;
    logic             id_reg_write;
    logic [LAT_W-1:0] id_lat;
    logic             ex_redirect;
    logic             mem_stall;
    logic             stall_if;
    logic             stall_id;
    logic             flush_id;
    logic             flush_ex;
    logic [LAT_W-1:0] fwd_a;
    logic [LAT_W-1:0] fwd_b;

    modport master (
        output id_valid, id_rs1, id_rs2, id_rs1_used, id_rs2_used,
               id_rd, id_reg_write, id_lat, ex_redirect, mem_stall,
        input  stall_if, stall_id, flush_id, flush_ex, fwd_a, fwd_b
    );

    modport slave (
        input  id_valid, id_rs1, id_rs2, id_rs1_used, id_rs2_used,
               id_rd, id_reg_write, id_lat, ex_redirect, mem_stall,
        output stall_if, stall_id, flush_id, flush_ex, fwd_a, fwd_b
    );
endinterface

// File: rtl/hazard_scoreboard.sv
// Shift-register write scoreboard EX..WB producing stall/flush/forward selects; HZ_FORWARD_EN enables bypassing.
// Outputs are zero-latency combinational; mem_stall freezes all state and holds IF/ID.
module hazard_scoreboard #(
    parameter int DEPTH = 3,
    parameter int RA_W  = 5,
    parameter int LAT_W = $clog2(DEPTH)
) (
    input  logic               clk,
    input  logic               reset,
    hazard_scoreboard_if.slave hz
);

    typedef struct packed {
        logic             vld;
        logic [RA_W-1:0]  rd;
        logic [LAT_W-1:0] lat;
    } sb_entry_t;

    localparam logic [LAT_W-1:0] LAT_SAT = LAT_W'(DEPTH - 2);

`ifdef HZ_FORWARD_EN
    localparam bit FWD_EN = 1'b1;
`else
    localparam bit FWD_EN = 1'b0;
`endif

    sb_entry_t        r_sb [DEPTH];
    logic [RA_W-1:0]  r_ex_rs1;
    logic [RA_W-1:0]  r_ex_rs2;
    logic             r_ex_rs1_used;
    logic             r_ex_rs2_used;

    sb_entry_t        w_issue;
    logic [RA_W-1:0]  w_id_src [2];
    logic [RA_W-1:0]  w_ex_src [2];
    logic [1:0]       w_id_use;
    logic [1:0]       w_ex_use;
    logic [1:0]       w_id_hit;
    logic [1:0]       w_id_hz;
    logic [1:0]       w_ex_hit;
    logic [1:0]       w_fwd_pend;
    logic [LAT_W-1:0] w_fwd [2];
    logic             w_stall;
    logic             w_flush_id;
    logic             w_flush_ex;

    always_comb begin
        w_issue.vld = hz.id_valid && hz.id_reg_write && (hz.id_rd != '0);
        w_issue.rd  = hz.id_rd;
        w_issue.lat = (hz.id_lat > LAT_SAT) ? LAT_SAT : hz.id_lat;
    end

    // Youngest ID match only; the WB stage is excluded since the register file writes through.
    always_comb begin
        w_id_src[0] = hz.id_rs1;
        w_id_src[1] = hz.id_rs2;
        w_id_use    = {hz.id_valid && hz.id_rs2_used, hz.id_valid && hz.id_rs1_used};
        w_id_hit    = '0;
        w_id_hz     = '0;
        for (int s = 0; s < 2; s++) begin
            for (int j = 0; j <= DEPTH - 2; j++) begin
                if (!w_id_hit[s] && w_id_use[s] && (w_id_src[s] != '0) &&
                    r_sb[j].vld && (r_sb[j].rd == w_id_src[s])) begin
                    w_id_hit[s] = 1'b1;
                    w_id_hz[s]  = !FWD_EN || (LAT_W'(j) < r_sb[j].lat);
                end
            end
        end
    end

    // A youngest EX match whose result is not yet available flags w_fwd_pend.
    always_comb begin
        w_ex_src[0] = r_ex_rs1;
        w_ex_src[1] = r_ex_rs2;
        w_ex_use    = {r_ex_rs2_used, r_ex_rs1_used};
        w_ex_hit    = '0;
        w_fwd_pend  = '0;
        w_fwd[0]    = '0;
        w_fwd[1]    = '0;
        for (int s = 0; s < 2; s++) begin
            for (int k = 1; k < DEPTH; k++) begin
                if (!w_ex_hit[s] && w_ex_use[s] && (w_ex_src[s] != '0) &&
                    r_sb[k].vld && (r_sb[k].rd == w_ex_src[s])) begin
                    w_ex_hit[s] = 1'b1;
                    if (FWD_EN && (LAT_W'(k) > r_sb[k].lat)) begin
                        w_fwd[s] = LAT_W'(k);
                    end else begin
                        w_fwd_pend[s] = 1'b1;
                    end
                end
            end
        end
    end

    always_comb begin
        w_stall    = 1'b0;
        w_flush_id = 1'b0;
        w_flush_ex = 1'b0;
        if (reset) begin
            if (hz.mem_stall) begin
                w_stall = 1'b1;
            end else if (hz.ex_redirect) begin
                w_flush_id = 1'b1;
                w_flush_ex = 1'b1;
            end else if (|w_id_hz) begin
                w_stall    = 1'b1;
                w_flush_ex = 1'b1;
            end
        end
    end

    assign hz.stall_if = w_stall;
    assign hz.stall_id = w_stall;
    assign hz.flush_id = w_flush_id;
    assign hz.flush_ex = w_flush_ex;
    assign hz.fwd_a    = reset ? w_fwd[0] : '0;
    assign hz.fwd_b    = reset ? w_fwd[1] : '0;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int k = 0; k < DEPTH; k++) begin
                r_sb[k] <= '0;
            end
            r_ex_rs1      <= '0;
            r_ex_rs2      <= '0;
            r_ex_rs1_used <= 1'b0;
            r_ex_rs2_used <= 1'b0;
        end else if (!hz.mem_stall) begin
            for (int k = 1; k < DEPTH; k++) begin
                r_sb[k] <= r_sb[k-1];
            end
            if (w_flush_ex) begin
                r_sb[0]       <= '0;
                r_ex_rs1      <= '0;
                r_ex_rs2      <= '0;
                r_ex_rs1_used <= 1'b0;
                r_ex_rs2_used <= 1'b0;
            end else begin
                r_sb[0]       <= w_issue;
                r_ex_rs1      <= hz.id_rs1;
                r_ex_rs2      <= hz.id_rs2;
                r_ex_rs1_used <= w_id_use[0];
                r_ex_rs2_used <= w_id_use[1];
            end
        end
    end

    // A consumer in EX must never depend on a result that is still in flight.
    a_fwd_ready: assert property (@(posedge clk) disable iff (!reset) w_fwd_pend == 2'b00);

endmodule
